frame_diff_bin: RTL and testbench
=================================

FRAME_DIFF_BIN -- requirements
Module: frame_diff_bin

Interface
REQ-001 Parameter IMG_WIDTH, default 11'd640, active pixels per line; used only for the line-length check.
REQ-002 Parameter DIFF_THRESH, default 8'd30, absolute-difference threshold for a motion pixel.
REQ-003 Parameter MOTION_MIN, default 20'd200, minimum motion pixels per frame for motion_flag.
REQ-004 clk  input  1  pixel clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 per_frame_vsync  input  1  current-frame vsync, high during the active frame.
REQ-007 per_frame_href  input  1  current-frame line valid.
REQ-008 per_frame_clken  input  1  pixel strobe.
REQ-009 per_img_Y  input  8  current-frame luma.
REQ-010 prev_img_Y  input  8  previous-frame luma, pixel-aligned with per_img_Y.
REQ-011 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  sync signals delayed 2 cycles, feeding the rectangle stage.
REQ-012 post_img_Y  output  1  binary motion pixel.
REQ-013 prev_valid  output  1  high once a full previous frame exists.
REQ-014 motion_cnt  output  20  motion-pixel count of the last completed frame.
REQ-015 motion_flag  output  1  high when motion_cnt >= MOTION_MIN.
REQ-016 line_err  output  1  sticky flag: a line had a clken count different from IMG_WIDTH.

Function
REQ-017 Stage 1 (cycle n+1) SHALL register diff = |per_img_Y - prev_img_Y| as an 8-bit unsigned value, computed with a compare-then-subtract so it never wraps.
- Stage 1 SHALL also register the three input sync signals.
REQ-018 Stage 2 (cycle n+2) SHALL set post_img_Y = 1 only when all of the following hold:
- diff > DIFF_THRESH (strictly greater);
- stage-1 clken and href are both 1;
- prev_valid = 1.
- Otherwise post_img_Y SHALL be 0.
REQ-019 post_frame_* SHALL equal the inputs delayed exactly 2 cycles; total latency is 2 cycles for all outputs.
REQ-020 Frame counter SHALL increment on each falling edge of per_frame_vsync and saturate at 2.
- prev_valid = (frame counter >= 1).
REQ-021 Line counter SHALL count per_frame_clken while per_frame_href is high.
- On the falling edge of href, a count != IMG_WIDTH SHALL set line_err.
- line_err SHALL stay set until reset.
REQ-022 Rising edge of post_frame_vsync SHALL clear the accumulator.

Reset
REQ-023 rst_n low SHALL asynchronously clear all of the following to 0:
- pipeline registers and post_* outputs;
- frame counter and prev_valid;
- accumulator, motion_cnt and motion_flag;
- line counter and line_err.
REQ-024 A reset mid-frame SHALL restart first-frame suppression: post_img_Y stays 0 until one complete frame has passed after reset release.

Configuration
REQ-025 Macro MOTION_CNT_EN SHALL compile the motion statistics in or out.
REQ-026 With MOTION_CNT_EN defined:
- The accumulator SHALL add 1 per cycle with post_frame_clken=1 and post_img_Y=1, saturating at 20'hFFFFF.
- On the falling edge of post_frame_vsync, motion_cnt SHALL latch the accumulator value held before that cycle and the accumulator SHALL clear.
- motion_flag SHALL update in the same cycle.
REQ-027 Without MOTION_CNT_EN:
- The accumulator SHALL be absent.
- motion_cnt SHALL be tied to 20'd0 and motion_flag to 0.
- All other behaviour SHALL be unchanged.

Verification
REQ-028 Reset, then the first 640x480 frame with Y=200, prev=0 -> post_img_Y = 0 throughout; prev_valid rises after the vsync falling edge.
REQ-029 Second frame, Y=100, prev=70 (diff 30) -> post_img_Y = 0; with prev=69 (diff 31) -> post_img_Y = 1, exactly 2 cycles after the input clken.
REQ-030 Y=10, prev=250 -> diff 240, post_img_Y = 1 (no wrap).
REQ-031 MOTION_CNT_EN defined, 200 motion pixels in a frame -> at post vsync fall, motion_cnt = 200 and motion_flag = 1; next frame with 199 -> motion_cnt = 199, motion_flag = 0.
REQ-032 A line with 639 clkens -> line_err = 1 after href falls and stays 1 through the following frames.
REQ-033 Assert rst_n at pixel 1000 of the second frame -> all outputs 0 immediately; output suppressed for the next full frame; MOTION_CNT_EN undefined -> motion_cnt remains 0 in every test.

Source files
------------

// File: rtl/frame_diff_bin.sv
// -----------------------------------------------------------------------------
// frame_diff_bin
// Two-stage frame-difference binarizer. Stage 1 registers |Y_cur - Y_prev| and
// the sync strobes; stage 2 produces a 1-bit motion pixel. Also tracks whether
// a full previous frame exists, checks line lengths, and (optionally) counts
// motion pixels per frame.
//
// Optional feature macro: MOTION_CNT_EN
//   defined   -> per-frame motion accumulator, motion_cnt / motion_flag live
//   undefined -> motion_cnt tied to 0, motion_flag tied to 0
//
// Ports
//   clk, rst_n              pixel clock, async active-low reset
//   per_frame_vsync/href/clken, per_img_Y   current-frame stream
//   prev_img_Y              previous-frame luma, pixel-aligned
//   post_frame_vsync/href/clken             sync delayed 2 cycles
//   post_img_Y              binary motion pixel (2-cycle latency)
//   prev_valid              a complete previous frame has been seen
//   motion_cnt, motion_flag motion statistics of the last completed frame
//   line_err                sticky: a line had a clken count != IMG_WIDTH
// -----------------------------------------------------------------------------
`default_nettype none

module frame_diff_bin #(
    parameter logic [10:0] IMG_WIDTH   = 11'd640,
    parameter logic [7:0]  DIFF_THRESH = 8'd30,
    parameter logic [19:0] MOTION_MIN  = 20'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_Y,
    input  logic [7:0]  prev_img_Y,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_Y,
    output logic        prev_valid,
    output logic [19:0] motion_cnt,
    output logic        motion_flag,
    output logic        line_err
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LINE_W = 11;
    localparam int unsigned FCNT_W = 2;

    // Compare-then-subtract: never wraps.
    logic [PIX_W-1:0] w_diff;
    assign w_diff = (per_img_Y >= prev_img_Y) ? PIX_W'(per_img_Y - prev_img_Y)
                                              : PIX_W'(prev_img_Y - per_img_Y);

    logic [PIX_W-1:0] r_diff;
    logic             r_vsync1;
    logic             r_href1;
    logic             r_clken1;

    // Stage 1: difference and sync strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_vsync1 <= 1'b0;
            r_href1  <= 1'b0;
            r_clken1 <= 1'b0;
        end else begin
            r_diff   <= w_diff;
            r_vsync1 <= per_frame_vsync;
            r_href1  <= per_frame_href;
            r_clken1 <= per_frame_clken;
        end
    end

    // Stage 2: binarize, gated by a valid previous frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= 1'b0;
        end else begin
            post_frame_vsync <= r_vsync1;
            post_frame_href  <= r_href1;
            post_frame_clken <= r_clken1;
            post_img_Y       <= (r_diff > DIFF_THRESH) && r_clken1 && r_href1 && prev_valid;
        end
    end

    // Edge detects on the input stream, using the stage-1 copies as history.
    logic w_vsync_fall;
    logic w_href_fall;
    assign w_vsync_fall = r_vsync1 & ~per_frame_vsync;
    assign w_href_fall  = r_href1  & ~per_frame_href;

    // Frame counter. A frame only counts if vsync was seen low before it,
    // so a frame interrupted by reset never enables output.
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_armed     <= 1'b0;
            prev_valid  <= 1'b0;
        end else begin
            if (!per_frame_vsync) begin
                r_armed <= 1'b1;
            end
            if (w_vsync_fall && r_armed && (r_frame_cnt != FCNT_W'(2))) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                prev_valid  <= 1'b1;
            end
        end
    end

    // Line-length check: clkens counted while href is high, judged on href fall.
    logic [LINE_W-1:0] r_line_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_cnt <= '0;
            line_err   <= 1'b0;
        end else if (w_href_fall) begin
            if (r_line_cnt != IMG_WIDTH) begin
                line_err <= 1'b1;
            end
            r_line_cnt <= '0;
        end else if (per_frame_href && per_frame_clken && (r_line_cnt != {LINE_W{1'b1}})) begin
            r_line_cnt <= r_line_cnt + LINE_W'(1);
        end
    end

`ifdef MOTION_CNT_EN
    localparam int unsigned CNT_W = 20;

    logic             r_post_vsync_d;
    logic [CNT_W-1:0] r_acc;

    // Motion statistics, aligned to the output-side frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_vsync_d <= 1'b0;
            r_acc          <= '0;
            motion_cnt     <= '0;
            motion_flag    <= 1'b0;
        end else begin
            r_post_vsync_d <= post_frame_vsync;
            if (r_post_vsync_d && !post_frame_vsync) begin
                motion_cnt  <= r_acc;
                motion_flag <= (r_acc >= MOTION_MIN);
                r_acc       <= '0;
            end else if (post_frame_vsync && !r_post_vsync_d) begin
                r_acc <= '0;
            end else if (post_frame_clken && post_img_Y && (r_acc != {CNT_W{1'b1}})) begin
                r_acc <= r_acc + CNT_W'(1);
            end
        end
    end
`else
    assign motion_cnt  = 20'd0;
    assign motion_flag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_diff_bin.sv
// -----------------------------------------------------------------------------
// tb_frame_diff_bin
// Randomized stimulus with a frame-level reference model. The driver pushes
// each pixel's expected motion bit and due cycle into a queue, and each
// frame's expected motion count into another; a negedge monitor pops and
// compares whenever the DUT presents a pixel or ends a frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_frame_diff_bin;

    localparam int unsigned W      = 16;
    localparam int unsigned H      = 16;
    localparam int unsigned THRESH = 30;
    localparam int unsigned MMIN   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [7:0]  per_img_Y;
    logic [7:0]  prev_img_Y;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic        post_img_Y;
    logic        prev_valid;
    logic [19:0] motion_cnt;
    logic        motion_flag;
    logic        line_err;

    always #5 clk = ~clk;

    frame_diff_bin #(
        .IMG_WIDTH   (11'(W)),
        .DIFF_THRESH (8'(THRESH)),
        .MOTION_MIN  (20'(MMIN))
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .prev_img_Y       (prev_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .prev_valid       (prev_valid),
        .motion_cnt       (motion_cnt),
        .motion_flag      (motion_flag),
        .line_err         (line_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned due;
        bit          v;
    } pix_t;

    pix_t        pix_q[$];
    int unsigned cnt_q[$];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference history of the input sync strobes, two cycles deep.
    logic [2:0] h1, h2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
            h2 <= h1;
        end
    end

    // Frame-level model state.
    int m_frames     = 0;
    bit m_line_err   = 0;
    int m_frame_ones = 0;

    // ---------------- monitor ----------------
    bit last_v       = 0;
    bit fall_pending = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_v       = 0;
            fall_pending = 0;
        end else begin
            if (fall_pending) begin
                if (cnt_q.size() == 0) begin
                    check("frame_count_queue_nonempty", 0, 1);
                end else begin
                    int unsigned c;
                    int unsigned exp_cnt;
                    c = cnt_q.pop_front();
`ifdef MOTION_CNT_EN
                    exp_cnt = c;
`else
                    exp_cnt = 0;
`endif
                    check("motion_cnt", motion_cnt, exp_cnt);
                    check("motion_flag", motion_flag, (exp_cnt >= MMIN) ? 1 : 0);
                end
            end
            fall_pending = last_v && !post_frame_vsync;
            last_v       = post_frame_vsync;

            check("post_sync_delay", {post_frame_vsync, post_frame_href, post_frame_clken}, h2);

            if (post_frame_clken) begin
                if (pix_q.size() == 0) begin
                    check("pixel_queue_nonempty", 0, 1);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    check("pixel_latency_cycle", cyc, e.due);
                    check("post_img_Y", post_img_Y, e.v);
                end
            end else begin
                check("post_img_Y_idle", post_img_Y, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_pixel(input logic [7:0] y, input logic [7:0] p);
        int  d;
        bit  e;
        pix_t item;
        d = int'(y) - int'(p);
        if (d < 0) d = -d;
        e = (d > int'(THRESH)) && (m_frames >= 1);
        item.due = cyc + 2;
        item.v   = e;
        pix_q.push_back(item);
        if (e) m_frame_ones++;
        per_img_Y       = y;
        prev_img_Y      = p;
        per_frame_clken = 1'b1;
        tick();
        per_frame_clken = 1'b0;
    endtask

    // mode 0 random, 1 threshold patterns, 2 first nmot pixels moving, 3 Y=200/prev=0
    task automatic drive_frame(input int mode, input int nmot, input int short_line, input int reset_line);
        bit          aborted;
        int          pix;
        int          n;
        logic [7:0]  y, p;
        aborted = 0;
        pix     = 0;
        per_frame_vsync = 1'b1;
        idle(3);
        for (int l = 0; l < int'(H); l++) begin
            if (l == reset_line) begin
                rst_n = 1'b0;
                #1;
                check("rst_post_vsync", post_frame_vsync, 0);
                check("rst_post_href", post_frame_href, 0);
                check("rst_post_clken", post_frame_clken, 0);
                check("rst_post_img_Y", post_img_Y, 0);
                check("rst_prev_valid", prev_valid, 0);
                check("rst_motion_cnt", motion_cnt, 0);
                check("rst_motion_flag", motion_flag, 0);
                check("rst_line_err", line_err, 0);
                pix_q.delete();
                cnt_q.delete();
                m_frames     = 0;
                m_line_err   = 0;
                m_frame_ones = 0;
                aborted      = 1;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
            end
            per_frame_href = 1'b1;
            n = (l == short_line) ? int'(W) - 1 : int'(W);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3) == 0) begin
                    per_img_Y  = 8'($urandom);
                    prev_img_Y = 8'($urandom);
                    tick();
                end
                y = 8'($urandom);
                p = 8'($urandom);
                case (mode)
                    1: case (pix % 6)
                           0: begin y = 8'd100; p = 8'd70;  end
                           1: begin y = 8'd100; p = 8'd69;  end
                           2: begin y = 8'd10;  p = 8'd250; end
                           3: begin y = 8'd70;  p = 8'd100; end
                           4: begin y = 8'd69;  p = 8'd100; end
                           default: ;
                       endcase
                    2: if (pix < nmot) begin y = 8'd10; p = 8'd250; end
                       else p = y;
                    3: begin y = 8'd200; p = 8'd0; end
                    default: ;
                endcase
                drive_pixel(y, p);
                pix++;
            end
            if (n != int'(W)) m_line_err = 1;
            idle(3);
        end
        per_frame_vsync = 1'b0;
        if (!aborted) m_frames++;
        cnt_q.push_back(m_frame_ones);
        m_frame_ones = 0;
        idle(8);
        check("prev_valid", prev_valid, (m_frames >= 1) ? 1 : 0);
        check("line_err", line_err, m_line_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Y       = '0;
        prev_img_Y      = '0;
        tick();
        tick();
        check("reset_prev_valid", prev_valid, 0);
        check("reset_line_err", line_err, 0);
        check("reset_motion_cnt", motion_cnt, 0);
        check("reset_post_img_Y", post_img_Y, 0);
        rst_n = 1'b1;
        idle(3);

        drive_frame(3, 0,   -1, -1);   // first frame: suppressed
        drive_frame(1, 0,   -1, -1);   // threshold boundary and no-wrap cases
        drive_frame(0, 0,   -1, -1);
        drive_frame(2, 200, -1, -1);   // exactly MOTION_MIN motion pixels
        drive_frame(2, 199, -1, -1);   // one below
        drive_frame(0, 0,   -1, 6);    // reset mid-frame
        drive_frame(3, 0,   -1, -1);   // full frame after reset: still suppressed
        drive_frame(0, 0,   -1, -1);
        drive_frame(0, 0,   5,  -1);   // short line
        drive_frame(0, 0,   -1, -1);   // line_err stays set
        idle(10);

        check("pixel_queue_drained", pix_q.size(), 0);
        check("frame_queue_drained", cnt_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
